scan_seq_ctrl: RTL
==================

Name: scan_seq_ctrl

Overview:
- Parametrised successor to the single-channel rotate/acquire FSM.
- Sequences a multi-position rotary scan. At each position it steps through every channel enabled in a mask, one RF switch path at a time. For each channel it waits a settle time, then holds an ADC acquire window. It then advances the rotator one step.
- Runs entirely in the fpga_clk domain. Step timing comes from a one-cycle step_tick strobe produced by the clock-divider block; the step clock is no longer used as a clock.

Parameters:
- N_CH, 4, number of RF switch channels (2..16)
- STEP_W, 10, width of rotation step counters
- DWELL_W, 8, width of the ADC dwell count
- SETTLE_TICKS, 2, step_ticks to wait after a channel switch before acquiring (>=1)

Ports:
- fpga_clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- step_tick  in  1  one-fpga_clk-cycle strobe at the step rate
- init  in  1  one-cycle pulse; abort and re-home
- trg  in  1  one-cycle pulse; start a scan
- cfg_steps  in  STEP_W  positions per scan
- cfg_ch_mask  in  N_CH  enabled channels
- cfg_dwell  in  DWELL_W  step_ticks per acquire window
- busy  out  1  scan in progress
- rot_en  out  1  rotator step enable
- adc_en  out  1  ADC acquire window
- rf_sel  out  N_CH  one-hot RF switch select
- ch_idx  out  $clog2(N_CH)  index of the active channel
- rot_count  out  STEP_W  absolute step position
- done  out  1  one-cycle pulse at scan end
- cfg_err  out  1  sticky flag: trigger rejected because of bad config

Behaviour:
- Reset (rst==0 on a fpga_clk edge): state IDLE; all outputs are 0, including rot_count and cfg_err.
- States: IDLE, SELECT, SETTLE, ACQ, MOVE, DONE.
- IDLE, on trg:
  - If cfg_ch_mask==0 or cfg_steps==0: set cfg_err and stay in IDLE.
  - Otherwise, next cycle: latch cfg_steps, cfg_ch_mask and cfg_dwell; clear cfg_err; set pos=0; go to SELECT. Channel search starts at index 0.
- SELECT (exactly 1 cycle):
  - ch_idx takes the lowest enabled index >= the search start; rf_sel becomes one-hot of ch_idx.
  - Go to SETTLE with the tick counter cleared.
- SETTLE: count step_ticks. On the SETTLE_TICKS-th tick go to ACQ and clear the tick counter.
- ACQ:
  - adc_en=1 for the whole state.
  - Count step_ticks. A latched cfg_dwell of 0 is treated as 1. On the dwell-th tick, leave ACQ:
    - if a higher enabled channel exists, go to SELECT with the search start set to ch_idx+1;
    - otherwise go to MOVE.
- MOVE:
  - rf_sel stays on the last channel; rot_en=1.
  - On the next step_tick: rot_count+=1 (modulo 2^STEP_W) and pos+=1. If pos+1==latched cfg_steps, go to DONE; otherwise go to SELECT with the search start at index 0.
- DONE: done=1 for 1 cycle; rf_sel and adc_en are cleared; go to IDLE. rot_count is held.
- busy=1 in every state except IDLE.
- A step_tick in the same cycle a state is entered is not counted; counting starts on the cycle after entry.
- init, in any state: next cycle is IDLE with rot_count=0, rf_sel=0, adc_en=0, rot_en=0, and no done pulse. cfg_err is not changed.
- init and trg in the same cycle: init wins and the trigger is discarded.
- trg while busy is ignored.
- Config inputs are sampled only at trigger acceptance. Changes during a scan have no effect until the next scan.
- Latency:
  - Outputs are registered.
  - From accepted trg to the first rf_sel: 2 cycles.
  - A single enabled channel at cfg_steps=1 yields 1 SELECT, 1 SETTLE, 1 ACQ, 1 MOVE, then DONE.

Decomposition:
- Shared package scan_pkg:
  - state enum;
  - default widths;
  - clog2-based CH_IDX_W.
- Sub-module scan_ch_pick: combinational "lowest set bit >= start" finder over N_CH, with outputs found and idx. It is instantiated once.
- The tick counter is sized max(DWELL_W, $clog2(SETTLE_TICKS+1)).

Test Plan:
- Reset, then idle: all outputs 0. trg with cfg_ch_mask=0 -> cfg_err=1, busy=0. A later valid trg clears cfg_err.
- N_CH=4, mask=4'b0101, cfg_steps=3, cfg_dwell=2, SETTLE_TICKS=1, step_tick every 4 cycles:
  - rf_sel sequence 0001,0100 repeated 3 times;
  - each adc_en window spans 2 ticks;
  - rot_en appears 3 times;
  - rot_count ends at 3;
  - exactly one done pulse.
- cfg_dwell=0, mask=4'b1000, cfg_steps=1 -> single ACQ of 1 tick; rf_sel=1000; done follows MOVE.
- init asserted mid-ACQ on pos 1 -> next cycle busy=0, adc_en=0, rf_sel=0, rot_count=0, no done pulse.
- init and trg in the same cycle while in IDLE -> no scan starts. trg pulsed mid-scan -> the scan completes unchanged, with no restart.
- STEP_W=4, rot_count preloaded to 14 by a prior scan of 14 steps, then cfg_steps=3 -> rot_count wraps 15,0,1; done fires on the third MOVE.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and default sizing for the rotary scan sequencer.
// Holds the FSM state encoding and helpers that size the channel index and tick counter.
package scan_pkg;

    localparam int DEF_N_CH         = 4;
    localparam int DEF_STEP_W       = 10;
    localparam int DEF_DWELL_W      = 8;
    localparam int DEF_SETTLE_TICKS = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_ACQ,
        S_MOVE,
        S_DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    localparam int DEF_CH_IDX_W = ch_idx_w(DEF_N_CH);

endpackage

// File: rtl/scan_seq_ctrl_if.sv
// Control/status bundle between the scan sequencer and its host.
// The host is the master; the sequencer is the slave.
interface scan_seq_ctrl_if
    import scan_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int STEP_W  = DEF_STEP_W,
    parameter int DWELL_W = DEF_DWELL_W
);
    localparam int CH_IDX_W = ch_idx_w(N_CH);

    logic                step_tick;
    logic                init;
    logic                trg;
    logic [STEP_W-1:0]   cfg_steps;
    logic [N_CH-1:0]     cfg_ch_mask;
    logic [DWELL_W-1:0]  cfg_dwell;
    logic                busy;
    logic                rot_en;
    logic                adc_en;
    logic [N_CH-1:0]     rf_sel;
    logic [CH_IDX_W-1:0] ch_idx;
    logic [STEP_W-1:0]   rot_count;
    logic                done;
    logic                cfg_err;

    modport master (
        output step_tick, init, trg, cfg_steps, cfg_ch_mask, cfg_dwell,
        input  busy, rot_en, adc_en, rf_sel, ch_idx, rot_count, done, cfg_err
    );

    modport slave (
        input  step_tick, init, trg, cfg_steps, cfg_ch_mask, cfg_dwell,
        output busy, rot_en, adc_en, rf_sel, ch_idx, rot_count, done, cfg_err
    );

endinterface

// File: rtl/scan_ch_pick.sv
// Combinational finder: lowest set bit of i_mask whose index is >= i_start.
// i_start is one bit wider than the index so "past the last channel" is representable.
module scan_ch_pick #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  i_mask,
    input  logic [IDX_W:0]   i_start,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_found = 1'b0;
        o_idx   = '0;
        // Descending scan: the last hit written is the lowest qualifying index.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && ((IDX_W + 1)'(i) >= i_start)) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/scan_seq_ctrl.sv
// Multi-position rotary scan sequencer: per position, settle and acquire on each enabled
// RF channel in ascending order, then step the rotator. All timing is in step_tick units.
module scan_seq_ctrl
    import scan_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int STEP_W       = DEF_STEP_W,
    parameter int DWELL_W      = DEF_DWELL_W,
    parameter int SETTLE_TICKS = DEF_SETTLE_TICKS
) (
    input  logic           fpga_clk,
    input  logic           rst,
    scan_seq_ctrl_if.slave bus
);

    localparam int CH_IDX_W = ch_idx_w(N_CH);
    localparam int TICK_W   = max_int(DWELL_W, $clog2(SETTLE_TICKS + 1));
    localparam logic [TICK_W-1:0] SETTLE_LAST = TICK_W'(SETTLE_TICKS);

    state_t              r_state;
    logic [STEP_W-1:0]   r_pos;
    logic [STEP_W-1:0]   r_steps;
    logic [N_CH-1:0]     r_mask;
    logic [DWELL_W-1:0]  r_dwell;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [CH_IDX_W-1:0] r_search_start;

    logic                r_busy;
    logic                r_rot_en;
    logic                r_adc_en;
    logic [N_CH-1:0]     r_rf_sel;
    logic [CH_IDX_W-1:0] r_ch_idx;
    logic [STEP_W-1:0]   r_rot_count;
    logic                r_done;
    logic                r_cfg_err;

    logic [CH_IDX_W:0]   w_pick_start;
    logic                w_found;
    logic [CH_IDX_W-1:0] w_idx;
    logic [TICK_W-1:0]   w_tick_next;
    logic [TICK_W-1:0]   w_dwell_last;
    logic [STEP_W-1:0]   w_pos_next;
    logic                w_cfg_ok;

    // In ACQ the picker looks ahead for a higher channel; otherwise it serves SELECT.
    assign w_pick_start = (r_state == S_ACQ) ? ({1'b0, r_ch_idx} + (CH_IDX_W + 1)'(1))
                                             : {1'b0, r_search_start};
    assign w_tick_next  = r_tick_cnt + TICK_W'(1);
    assign w_dwell_last = (r_dwell == '0) ? TICK_W'(1) : TICK_W'(r_dwell);
    assign w_pos_next   = r_pos + STEP_W'(1);
    assign w_cfg_ok     = (bus.cfg_ch_mask != '0) && (bus.cfg_steps != '0);

    scan_ch_pick #(
        .N_CH  (N_CH),
        .IDX_W (CH_IDX_W)
    ) u_pick (
        .i_mask  (r_mask),
        .i_start (w_pick_start),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
    always_ff @(posedge fpga_clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_pos          <= '0;
            r_steps        <= '0;
            r_mask         <= '0;
            r_dwell        <= '0;
            r_tick_cnt     <= '0;
            r_search_start <= '0;
            r_busy         <= 1'b0;
            r_rot_en       <= 1'b0;
            r_adc_en       <= 1'b0;
            r_rf_sel       <= '0;
            r_ch_idx       <= '0;
            r_rot_count    <= '0;
            r_done         <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else if (bus.init) begin
            // Abort and re-home; a simultaneous trg is dropped and cfg_err is left alone.
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_busy      <= 1'b0;
            r_rot_en    <= 1'b0;
            r_adc_en    <= 1'b0;
            r_rf_sel    <= '0;
            r_ch_idx    <= '0;
            r_rot_count <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.trg) begin
                        if (!w_cfg_ok) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_steps        <= bus.cfg_steps;
                            r_mask         <= bus.cfg_ch_mask;
                            r_dwell        <= bus.cfg_dwell;
                            r_cfg_err      <= 1'b0;
                            r_pos          <= '0;
                            r_search_start <= '0;
                            r_busy         <= 1'b1;
                            r_state        <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    r_ch_idx   <= w_idx;
                    r_rf_sel   <= N_CH'(1) << w_idx;
                    r_tick_cnt <= '0;
                    r_state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (bus.step_tick) begin
                        if (w_tick_next == SETTLE_LAST) begin
                            r_tick_cnt <= '0;
                            r_adc_en   <= 1'b1;
                            r_state    <= S_ACQ;
                        end else begin
                            r_tick_cnt <= w_tick_next;
                        end
                    end
                end
                S_ACQ: begin
                    if (bus.step_tick) begin
                        if (w_tick_next == w_dwell_last) begin
                            r_tick_cnt <= '0;
                            r_adc_en   <= 1'b0;
                            if (w_found) begin
                                r_search_start <= w_pick_start[CH_IDX_W-1:0];
                                r_state        <= S_SELECT;
                            end else begin
                                r_rot_en <= 1'b1;
                                r_state  <= S_MOVE;
                            end
                        end else begin
                            r_tick_cnt <= w_tick_next;
                        end
                    end
                end
                S_MOVE: begin
                    if (bus.step_tick) begin
                        r_rot_count <= r_rot_count + STEP_W'(1);
                        r_pos       <= w_pos_next;
                        r_rot_en    <= 1'b0;
                        if (w_pos_next == r_steps) begin
                            r_done   <= 1'b1;
                            r_rf_sel <= '0;
                            r_state  <= S_DONE;
                        end else begin
                            r_search_start <= '0;
                            r_state        <= S_SELECT;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.rot_en    = r_rot_en;
    assign bus.adc_en    = r_adc_en;
    assign bus.rf_sel    = r_rf_sel;
    assign bus.ch_idx    = r_ch_idx;
    assign bus.rot_count = r_rot_count;
    assign bus.done      = r_done;
    assign bus.cfg_err   = r_cfg_err;

endmodule
